// File: rtl/frame_ring_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : frame_ring_buffer
//  Description : Circular store of 9-bit bytes ([8] = end-of-frame) placed
//                in front of the header decoder. Only complete frames become
//                visible to the consumer. The consumer reads committed bytes
//                through a random-access port and frees storage by latching a
//                new tail address.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk                  : clock
//    rst_n                : asynchronous active-low reset
//    wr_data[8:0]         : write byte, [8] = end-of-frame, [7:0] = payload
//    wr_valid             : write strobe, one byte per cycle
//    wr_full              : no write would be accepted this cycle
//    overflow             : sticky, a frame was dropped because of full buffer
//    overflow_clear       : clears overflow (a same-cycle new event wins)
//    out_frame_valid      : at least one committed frame is stored
//    out_frame_tail       : address of the first byte of the oldest frame
//    out_frame_addr       : consumer read address
//    out_frame_data[8:0]  : registered read data (1 cycle latency)
//    out_frame_data_valid : out_frame_data matches out_frame_addr and that
//                           location holds a committed byte
//    out_frame_latch_tail : release storage: tail <= out_frame_addr
// ============================================================================
module frame_ring_buffer #(
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [8:0]            wr_data,
    input  logic                  wr_valid,
    output logic                  wr_full,
    output logic                  overflow,
    input  logic                  overflow_clear,
    output logic                  out_frame_valid,
    output logic [ADDR_WIDTH-1:0] out_frame_tail,
    input  logic [ADDR_WIDTH-1:0] out_frame_addr,
    output logic [8:0]            out_frame_data,
    output logic                  out_frame_data_valid,
    input  logic                  out_frame_latch_tail
);

    localparam int                    c_DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_ONE   = ADDR_WIDTH'(1);

    typedef enum logic [0:0] {
        ST_ACCEPT  = 1'b0,
        ST_DISCARD = 1'b1
    } state_t;

    // Storage (contents are not reset)
    logic [8:0]            r_ram [c_DEPTH];

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_head;
    logic [ADDR_WIDTH-1:0] r_commit;
    logic [ADDR_WIDTH-1:0] r_tail;
    logic [ADDR_WIDTH-1:0] r_frame_count;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [8:0]            r_rd_data;
    logic                  r_overflow;

    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] w_head_nxt;
    logic [ADDR_WIDTH-1:0] w_commit_nxt;
    logic [ADDR_WIDTH-1:0] w_head_inc;
    logic                  w_full;
    logic                  w_eof;
    logic                  w_ram_we;
    logic                  w_commit_evt;
    logic                  w_ovf_evt;
    logic                  w_release;
    logic [ADDR_WIDTH-1:0] w_rel_addr;
    logic [ADDR_WIDTH-1:0] w_rel_commit;

    // One slot is always left empty so head == tail unambiguously means empty.
    // Fullness uses the current tail: a same-cycle release only helps next cycle.
    assign w_head_inc = r_head + c_ONE;
    assign w_full     = (w_head_inc == r_tail);
    assign w_eof      = wr_data[8];
    assign w_release  = out_frame_latch_tail && (r_frame_count != '0);

    // ------------------------------------------------------------------------
    // Write state machine: next state and write-side pointer updates
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_head_nxt   = r_head;
        w_commit_nxt = r_commit;
        w_ram_we     = 1'b0;
        w_commit_evt = 1'b0;
        w_ovf_evt    = 1'b0;
        case (r_state)
            ST_ACCEPT: begin
                if (wr_valid) begin
                    if (!w_full) begin
                        w_ram_we   = 1'b1;
                        w_head_nxt = w_head_inc;
                        if (w_eof) begin
                            w_commit_nxt = w_head_inc;
                            w_commit_evt = 1'b1;
                        end
                    end else begin
                        // Drop the partial frame by rewinding to the last
                        // commit point. If this byte was not the frame end,
                        // the rest of the frame must be swallowed as well.
                        w_head_nxt = r_commit;
                        w_ovf_evt  = 1'b1;
                        if (!w_eof) begin
                            w_state_nxt = ST_DISCARD;
                        end
                    end
                end
            end
            ST_DISCARD: begin
                if (wr_valid && w_eof) begin
                    w_state_nxt = ST_ACCEPT;
                end
            end
            default: begin
                w_state_nxt = ST_ACCEPT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_ACCEPT;
            r_head        <= '0;
            r_commit      <= '0;
            r_tail        <= '0;
            r_frame_count <= '0;
            r_overflow    <= 1'b0;
            r_rd_addr     <= '0;
            r_rd_data     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_head    <= w_head_nxt;
            r_commit  <= w_commit_nxt;
            r_rd_addr <= out_frame_addr;
            r_rd_data <= r_ram[out_frame_addr];

            if (w_release) begin
                r_tail <= out_frame_addr;
            end

            // A commit and a release in the same cycle cancel out.
            if (w_commit_evt && !w_release) begin
                r_frame_count <= r_frame_count + c_ONE;
            end else if (!w_commit_evt && w_release) begin
                r_frame_count <= r_frame_count - c_ONE;
            end

            if (w_ovf_evt) begin
                r_overflow <= 1'b1;
            end else if (overflow_clear) begin
                r_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_ram_we && rst_n) begin
            r_ram[r_head] <= wr_data;
        end
    end

    // ------------------------------------------------------------------------
    // Read side: a location is committed when its distance from tail is
    // smaller than the committed span. The address compare masks the one
    // cycle after an address change where the data register is stale.
    // ------------------------------------------------------------------------
    assign w_rel_addr   = out_frame_addr - r_tail;
    assign w_rel_commit = r_commit - r_tail;

    assign out_frame_data_valid = (r_rd_addr == out_frame_addr) &&
                                  (w_rel_addr < w_rel_commit);
    assign out_frame_data       = r_rd_data;
    assign out_frame_valid      = (r_frame_count != '0);
    assign out_frame_tail       = r_tail;
    assign wr_full              = w_full;
    assign overflow             = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_frame_ring_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_ring_buffer
//  Description : Self-checking bench for frame_ring_buffer (ADDR_WIDTH = 3).
//                Directed scenarios plus randomized traffic against a
//                queue-based reference model of the frame store.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_ring_buffer;

    localparam int AW = 3;
    localparam int D  = 1 << AW;

    logic          clk            = 1'b0;
    logic          rst_n          = 1'b0;
    logic [8:0]    wr_data        = '0;
    logic          wr_valid       = 1'b0;
    logic          overflow_clear = 1'b0;
    logic          latch          = 1'b0;
    logic [AW-1:0] addr           = '0;
    logic          wr_full;
    logic          overflow;
    logic          out_frame_valid;
    logic [AW-1:0] out_frame_tail;
    logic [8:0]    out_frame_data;
    logic          out_frame_data_valid;

    int n_tests = 0;
    int n_fail  = 0;

    frame_ring_buffer #(.ADDR_WIDTH(AW)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .wr_data              (wr_data),
        .wr_valid             (wr_valid),
        .wr_full              (wr_full),
        .overflow             (overflow),
        .overflow_clear       (overflow_clear),
        .out_frame_valid      (out_frame_valid),
        .out_frame_tail       (out_frame_tail),
        .out_frame_addr       (addr),
        .out_frame_data       (out_frame_data),
        .out_frame_data_valid (out_frame_data_valid),
        .out_frame_latch_tail (latch)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: committed span length, a queue of committed frame
    // lengths and a queue holding the frame currently being received.
    // ------------------------------------------------------------------
    logic [8:0] m_mem [D];
    int         m_tail;
    int         m_cbytes;
    int         m_flen[$];
    logic [8:0] m_part[$];
    bit         m_ovf;
    bit         m_disc;
    logic [8:0] m_data;
    int         m_rdq;

    function automatic int md(int x);
        return ((x % D) + D) % D;
    endfunction

    function automatic int m_head();
        return md(m_tail + m_cbytes + m_part.size());
    endfunction

    function automatic bit m_full();
        return (m_cbytes + m_part.size()) == (D - 1);
    endfunction

    function automatic bit m_dv(int a);
        return (m_rdq == a) && (md(a - m_tail) < m_cbytes);
    endfunction

    task automatic model_reset();
        m_tail   = 0;
        m_cbytes = 0;
        m_flen.delete();
        m_part.delete();
        m_ovf    = 1'b0;
        m_disc   = 1'b0;
        m_data   = '0;
        m_rdq    = 0;
    endtask

    task automatic model_clock();
        int a;
        int h;
        bit rel;
        bit full;
        bit ovf_set;
        a       = int'(addr);
        h       = m_head();
        rel     = latch && (m_flen.size() != 0);
        full    = m_full();
        ovf_set = 1'b0;
        m_data  = m_mem[a];
        m_rdq   = a;
        if (wr_valid) begin
            if (!m_disc) begin
                if (!full) begin
                    m_mem[h] = wr_data;
                    m_part.push_back(wr_data);
                    if (wr_data[8]) begin
                        m_cbytes += m_part.size();
                        m_flen.push_back(m_part.size());
                        m_part.delete();
                    end
                end else begin
                    m_part.delete();
                    ovf_set = 1'b1;
                    if (!wr_data[8]) m_disc = 1'b1;
                end
            end else if (wr_data[8]) begin
                m_disc = 1'b0;
            end
        end
        if (rel) begin
            m_cbytes -= md(a - m_tail);
            m_tail    = a;
            void'(m_flen.pop_front());
        end
        if (ovf_set) m_ovf = 1'b1;
        else if (overflow_clear) m_ovf = 1'b0;
    endtask

    // One clock: model follows the DUT at the rising edge, returns at the
    // falling edge where the next inputs are driven.
    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_clock();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        wr_valid       = 1'b0;
        wr_data        = '0;
        latch          = 1'b0;
        overflow_clear = 1'b0;
        addr           = '0;
        step();
        step();
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic write_byte(input logic [8:0] b);
        wr_valid = 1'b1;
        wr_data  = b;
        step();
        wr_valid = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        do_reset();
        #1;
        n_tests++;
        if ({wr_full, overflow, out_frame_valid, out_frame_data_valid} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags got=%b exp=0000",
                     {wr_full, overflow, out_frame_valid, out_frame_data_valid});
        end
        n_tests++;
        if (out_frame_tail !== '0 || out_frame_data !== '0) begin
            n_fail++;
            $display("FAIL reset_tail_data got tail=%0d data=%h exp 0/000",
                     out_frame_tail, out_frame_data);
        end
    endtask

    task automatic test_single_frame();
        do_reset();
        write_byte(9'h005);
        write_byte(9'h002);
        write_byte(9'h0AA);
        #1;
        n_tests++;
        if (out_frame_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pre_valid got=%b exp=0", out_frame_valid);
        end
        write_byte(9'h1BB);
        #1;
        n_tests++;
        if (out_frame_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL single_valid got=%b exp=1", out_frame_valid);
        end
        n_tests++;
        if (out_frame_data_valid !== 1'b1 || out_frame_data !== 9'h005) begin
            n_fail++;
            $display("FAIL single_addr0 got dv=%b data=%h exp dv=1 data=005",
                     out_frame_data_valid, out_frame_data);
        end
        addr = 3'd1;
        #1;
        n_tests++;
        if (out_frame_data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_addr_step_gap got dv=%b exp=0", out_frame_data_valid);
        end
        step();
        #1;
        n_tests++;
        if (out_frame_data_valid !== 1'b1 || out_frame_data !== 9'h002) begin
            n_fail++;
            $display("FAIL single_addr1 got dv=%b data=%h exp dv=1 data=002",
                     out_frame_data_valid, out_frame_data);
        end
        addr = 3'd4;
        step();
        step();
        #1;
        n_tests++;
        if (out_frame_data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_addr4 got dv=%b exp=0", out_frame_data_valid);
        end
    endtask

    task automatic test_partial_frame();
        do_reset();
        write_byte(9'h011);
        write_byte(9'h022);
        step();
        #1;
        n_tests++;
        if (out_frame_valid !== 1'b0 || out_frame_data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL partial_hidden got valid=%b dv=%b exp 0/0",
                     out_frame_valid, out_frame_data_valid);
        end
        write_byte(9'h133);
        step();
        #1;
        n_tests++;
        if (out_frame_valid !== 1'b1 || out_frame_data_valid !== 1'b1 ||
            out_frame_data !== 9'h011) begin
            n_fail++;
            $display("FAIL partial_commit got valid=%b dv=%b data=%h exp 1/1/011",
                     out_frame_valid, out_frame_data_valid, out_frame_data);
        end
        addr = 3'd2;
        step();
        #1;
        n_tests++;
        if (out_frame_data_valid !== 1'b1 || out_frame_data !== 9'h133) begin
            n_fail++;
            $display("FAIL partial_addr2 got dv=%b data=%h exp 1/133",
                     out_frame_data_valid, out_frame_data);
        end
    endtask

    task automatic test_release_wrap();
        logic [8:0] b;
        int         base;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            base = md(3 * k);
            for (int j = 0; j < 3; j++) begin
                b = 9'(16 * k + j + 1);
                if (j == 2) b[8] = 1'b1;
                write_byte(b);
            end
            for (int j = 0; j < 3; j++) begin
                b = 9'(16 * k + j + 1);
                if (j == 2) b[8] = 1'b1;
                addr = AW'(md(base + j));
                step();
                #1;
                n_tests++;
                if (out_frame_data_valid !== 1'b1 || out_frame_data !== b) begin
                    n_fail++;
                    $display("FAIL wrap_read f%0d a%0d got dv=%b data=%h exp 1/%h",
                             k, md(base + j), out_frame_data_valid, out_frame_data, b);
                end
            end
            addr  = AW'(md(base + 3));
            latch = 1'b1;
            step();
            latch = 1'b0;
            #1;
            n_tests++;
            if (out_frame_tail !== AW'(md(3 * (k + 1))) || out_frame_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL wrap_tail f%0d got tail=%0d valid=%b exp %0d/0",
                         k, out_frame_tail, out_frame_valid, md(3 * (k + 1)));
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        write_byte(9'h001);
        write_byte(9'h002);
        write_byte(9'h003);
        write_byte(9'h104);
        write_byte(9'h005);
        write_byte(9'h006);
        write_byte(9'h007);
        #1;
        n_tests++;
        if (wr_full !== 1'b1 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_full got full=%b ovf=%b exp 1/0", wr_full, overflow);
        end
        write_byte(9'h008);
        #1;
        n_tests++;
        if (overflow !== 1'b1 || wr_full !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_set got ovf=%b full=%b exp 1/0", overflow, wr_full);
        end
        write_byte(9'h1EE);
        write_byte(9'h0A1);
        write_byte(9'h1A2);
        addr = 3'd4;
        step();
        #1;
        n_tests++;
        if (out_frame_data_valid !== 1'b1 || out_frame_data !== 9'h0A1 ||
            out_frame_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_next_frame got dv=%b data=%h valid=%b exp 1/0A1/1",
                     out_frame_data_valid, out_frame_data, out_frame_valid);
        end
        overflow_clear = 1'b1;
        step();
        overflow_clear = 1'b0;
        #1;
        n_tests++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear got=%b exp=0", overflow);
        end
    endtask

    task automatic test_commit_and_release();
        do_reset();
        write_byte(9'h0C1);
        write_byte(9'h1C2);
        write_byte(9'h0C3);
        write_byte(9'h1C4);
        write_byte(9'h0C5);
        addr  = 3'd2;
        latch = 1'b1;
        write_byte(9'h1C6);
        latch = 1'b0;
        #1;
        n_tests++;
        if (out_frame_valid !== 1'b1 || out_frame_tail !== 3'd2) begin
            n_fail++;
            $display("FAIL simul_first got valid=%b tail=%0d exp 1/2",
                     out_frame_valid, out_frame_tail);
        end
        addr  = 3'd4;
        latch = 1'b1;
        step();
        #1;
        n_tests++;
        if (out_frame_valid !== 1'b1 || out_frame_tail !== 3'd4) begin
            n_fail++;
            $display("FAIL simul_second got valid=%b tail=%0d exp 1/4",
                     out_frame_valid, out_frame_tail);
        end
        addr = 3'd6;
        step();
        latch = 1'b0;
        #1;
        n_tests++;
        if (out_frame_valid !== 1'b0 || out_frame_tail !== 3'd6) begin
            n_fail++;
            $display("FAIL simul_last got valid=%b tail=%0d exp 0/6",
                     out_frame_valid, out_frame_tail);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        write_byte(9'h001);
        write_byte(9'h102);
        write_byte(9'h033);
        addr = 3'd1;
        step();
        #1;
        n_tests++;
        if (out_frame_data_valid !== 1'b1 || out_frame_data !== 9'h102) begin
            n_fail++;
            $display("FAIL arst_pre got dv=%b data=%h exp 1/102",
                     out_frame_data_valid, out_frame_data);
        end
        wr_valid = 1'b1;
        wr_data  = 9'h044;
        #1;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({out_frame_valid, out_frame_data_valid, wr_full, overflow} !== 4'b0000 ||
            out_frame_tail !== '0 || out_frame_data !== '0) begin
            n_fail++;
            $display("FAIL arst_immediate got valid=%b dv=%b full=%b ovf=%b tail=%0d data=%h exp zeros",
                     out_frame_valid, out_frame_data_valid, wr_full, overflow,
                     out_frame_tail, out_frame_data);
        end
        wr_valid = 1'b0;
        step();
        rst_n = 1'b1;
        model_reset();
        addr = 3'd0;
        step();
        #1;
        n_tests++;
        if (out_frame_data_valid !== 1'b0 || out_frame_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_post got dv=%b valid=%b exp 0/0",
                     out_frame_data_valid, out_frame_valid);
        end
        write_byte(9'h0F0);
        write_byte(9'h1F1);
        #1;
        n_tests++;
        if (out_frame_data_valid !== 1'b1 || out_frame_data !== 9'h0F0) begin
            n_fail++;
            $display("FAIL arst_new_frame got dv=%b data=%h exp 1/0F0",
                     out_frame_data_valid, out_frame_data);
        end
    endtask

    task automatic test_random();
        bit exp_dv;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            wr_valid       = ($urandom_range(0, 3) != 0);
            wr_data        = {1'($urandom_range(0, 3) == 0), 8'($urandom)};
            overflow_clear = ($urandom_range(0, 15) == 0);
            if (m_flen.size() != 0 && $urandom_range(0, 5) == 0) begin
                latch = 1'b1;
                addr  = AW'(md(m_tail + m_flen[0]));
            end else begin
                latch = (m_flen.size() == 0) && ($urandom_range(0, 20) == 0);
                if ($urandom_range(0, 2) == 0)
                    addr = AW'(md(m_tail + int'($urandom_range(0, m_cbytes + 1))));
            end
            #1;
            exp_dv = m_dv(int'(addr));
            n_tests++;
            if (wr_full !== m_full()) begin
                n_fail++;
                $display("FAIL rnd_full cyc=%0d got=%b exp=%b", cyc, wr_full, m_full());
            end
            n_tests++;
            if (out_frame_valid !== (m_flen.size() != 0)) begin
                n_fail++;
                $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, out_frame_valid,
                         (m_flen.size() != 0));
            end
            n_tests++;
            if (out_frame_tail !== AW'(m_tail) || overflow !== m_ovf) begin
                n_fail++;
                $display("FAIL rnd_tail_ovf cyc=%0d got tail=%0d ovf=%b exp %0d/%b",
                         cyc, out_frame_tail, overflow, m_tail, m_ovf);
            end
            n_tests++;
            if (out_frame_data_valid !== exp_dv) begin
                n_fail++;
                $display("FAIL rnd_dv cyc=%0d addr=%0d got=%b exp=%b", cyc, addr,
                         out_frame_data_valid, exp_dv);
            end
            if (exp_dv) begin
                n_tests++;
                if (out_frame_data !== m_data) begin
                    n_fail++;
                    $display("FAIL rnd_data cyc=%0d addr=%0d got=%h exp=%h", cyc, addr,
                             out_frame_data, m_data);
                end
            end
            step();
        end
        wr_valid       = 1'b0;
        latch          = 1'b0;
        overflow_clear = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_single_frame();
        test_partial_frame();
        test_release_wrap();
        test_overflow();
        test_commit_and_release();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/frame_ring_buffer.md
Name: frame_ring_buffer

Overview:
- Circular frame store directly upstream of the header decoder.
- Accepts 9-bit bytes from the host receive path; bit 8 marks the last byte of a frame.
- Commits only complete frames. Exposes them to the consumer through a random-access read port (tail + consumer-driven address).
- Releases frame storage when the consumer latches a new tail.

Parameters:
ADDR_WIDTH, 9, log2 of buffer depth (DEPTH = 2^ADDR_WIDTH entries, 9 bits each)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
wr_data  input  9  write byte; [8]=end-of-frame, [7:0]=payload
wr_valid  input  1  write strobe, one byte per cycle
wr_full  output  1  buffer full (no write would be accepted this cycle)
overflow  output  1  sticky; a frame was dropped due to full buffer
overflow_clear  input  1  clears overflow
out_frame_valid  output  1  at least one committed frame present
out_frame_tail  output  ADDR_WIDTH  address of first byte of oldest frame
out_frame_addr  input  ADDR_WIDTH  consumer read address
out_frame_data  output  9  registered read data
out_frame_data_valid  output  1  out_frame_data belongs to current out_frame_addr and that location is committed
out_frame_latch_tail  input  1  release storage: tail <= out_frame_addr, frame count -1

Behaviour:
- Reset (async, rst_n=0) sets:
  - head, commit, tail = 0; frame_count = 0; overflow = 0; discard = 0
  - out_frame_data = 0; rd_addr_q = 0
  - wr_full = 0, out_frame_valid = 0, out_frame_data_valid = 0
  - RAM contents are not reset.
- Reset asserted mid-frame loses all stored data, including partial frames. No state survives.
- Pointer arithmetic is modulo DEPTH (natural ADDR_WIDTH wrap).
- wr_full = ((head+1) mod DEPTH == tail). One slot is always unused, so capacity is DEPTH-1 bytes.
- Write state machine:
  - ACCEPT (discard=0), when wr_valid:
    - Not full: RAM[head] <= wr_data; head <= head+1.
    - If wr_data[8]=1: commit <= head+1; frame_count +1.
    - Full and wr_data[8]=0: byte dropped; head <= commit (partial frame rewound); overflow <= 1; discard <= 1.
    - Full and wr_data[8]=1: byte dropped; head <= commit; overflow <= 1; discard stays 0.
  - DISCARD (discard=1): every wr_valid byte is dropped. A byte with [8]=1 sets discard <= 0. The next byte starts a new frame in ACCEPT.
- overflow_clear clears overflow. If clear and a new overflow event occur in the same cycle, set wins.
- Read port:
  - out_frame_data <= RAM[out_frame_addr] every cycle; rd_addr_q <= out_frame_addr. Latency is 1 cycle.
  - out_frame_data_valid = (rd_addr_q == out_frame_addr) && committed(out_frame_addr).
  - committed(a) = ((a - tail) mod DEPTH) < ((commit - tail) mod DEPTH).
  - Consequences: after any address change, data_valid is low for exactly 1 cycle. It stays low while the address is beyond commit.
  - Bytes of the frame currently being written are never valid.
- out_frame_valid = (frame_count != 0). It rises the cycle after the last byte is accepted.
- out_frame_tail = tail.
- out_frame_latch_tail:
  - If frame_count != 0: tail <= out_frame_addr; frame_count -1.
  - If frame_count == 0: ignored.
  - The consumer guarantees the address is the byte after an end-of-frame byte.
- Same cycle commit and latch_tail: frame_count unchanged; both pointers update.
- wr_full is evaluated against the pre-update tail. A latch_tail in the same cycle does not make room until the next cycle.
- frame_count width is ADDR_WIDTH. It cannot exceed DEPTH-1 because each frame occupies at least 1 byte.

Test Plan:
- Single frame:
  - Stimulus: write 0x005, 0x002, 0x0AA, 0x1BB; set out_frame_addr=0.
  - Response: out_frame_valid=1 the cycle after 0x1BB. data_valid=1 with data 0x005 at addr 0 from that cycle (addr held). data_valid=0 for 1 cycle after stepping addr to 1, then data 0x002. addr 4 gives data_valid=0.
- Partial frame invisible:
  - Stimulus: write 0x011, 0x022 (no end mark).
  - Response: out_frame_valid=0; addr 0 gives data_valid=0. Writing 0x133 then makes all three valid.
- Release and wrap (ADDR_WIDTH=3):
  - Stimulus: write and consume three 3-byte frames, pulsing latch_tail with addr=tail+3 each time.
  - Response: tail goes 0→3→6→1; frame_count returns to 0; the third frame's bytes occupy RAM 6,7,0 and read back correctly.
- Overflow (ADDR_WIDTH=3):
  - Stimulus: commit frame of 4 bytes; write 4 more bytes without end mark, then 0x1EE.
  - Response: 4th extra byte is dropped; head rewinds to 4; overflow=1; discard until 0x1EE, which is also dropped. Next frame writes from address 4. overflow_clear then drops overflow to 0.
- Simultaneous commit and release:
  - Stimulus: two frames stored; latch_tail in the same cycle as a third frame's end byte.
  - Response: frame_count stays 2; out_frame_valid stays 1.
- Async reset mid-frame:
  - Stimulus: drop rst_n between clock edges during a write.
  - Response: outputs go to reset values immediately. Post-reset, addr 0 gives data_valid=0 until a new frame commits.
